wm8731_i2c_responder: RTL and testbench
=======================================

# wm8731_i2c_responder

Synthesizable I2C write-only responder emulating the WM8731/WM8731L codec control port. It is the device-side counterpart of the audio controller's I2C configuration master. It decodes 7-bit-address write transactions carrying the codec's 16-bit register words ({reg_addr[6:0], data[8:0]}), ACKs them, and holds the resulting 9-bit register file. It sits in the codec model and bench, or in an FPGA codec emulator, sampling SCL/SDA with the system clock.

## Interface
- DEV_ADDR, 7'h1A: 7-bit I2C device address matched.
- SYNC_STAGES, 2: synchronizer depth on scl_i/sda_i (minimum 2).
- clk  in  1  system clock; must run at least 10x the SCL rate.
- rst  in  1  reset; one clock domain, synchronous, active-high.
- scl_i  in  1  SCL pin level (async).
- sda_i  in  1  SDA pin level (async).
- sda_oe  out  1  1 = pull SDA low (open-drain); bench/top drives 0 when set, else z.
- reg_wr  out  1  one-cycle pulse on committed register write.
- reg_addr  out  7  address of last committed write.
- reg_data  out  9  data of last committed write.
- rd_addr  in  4  register file read index (0-9).
- rd_data  out  9  combinational read of register rd_addr; 0 for indexes 10-15.
- busy  out  1  high from START detect until STOP detect.

## Operation
- scl/sda pass through SYNC_STAGES flops, then one history flop for edge detection.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are detected in every state.
- Data bits are sampled on SCL rising edge, MSB first. sda_oe changes only on the cycle after an SCL falling edge.
- States:
  - IDLE: wait for START; START -> ADDR.
  - ADDR: shift 8 bits.
    - If {DEV_ADDR,1'b0} matches -> ADDR_ACK.
    - Otherwise (wrong address or R/W=1) -> WAIT_STOP, no ACK.
  - ADDR_ACK, ACK0, ACK1: assert sda_oe for one SCL period.
  - BYTE0 shifts {reg_addr, data[8]}, then ACK0.
  - BYTE1 shifts data[7:0], then ACK1.
  - After ACK1 -> WAIT_STOP. Any further bytes are not ACKed.
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- Any START (including repeated) -> ADDR with counters cleared. Any STOP -> IDLE with sda_oe=0.
- Commit happens on the SCL falling edge that ends ACK1:
  - reg_wr=1 for one cycle; reg_addr/reg_data update the same cycle.
  - If reg_addr in 0x00-0x09, the register file entry is written.
  - Other addresses are still ACKed and pulsed, with no storage change (0x0F: see Configuration).
- A STOP or START before ACK1 completes means no commit.
- Register defaults: R0 0x097, R1 0x097, R2 0x079, R3 0x079, R4 0x00A, R5 0x008, R6 0x09F, R7 0x00A, R8 0x000, R9 0x000.

## Timing
- Reset values:
  - sda_oe=0, reg_wr=0, reg_addr=0, reg_data=0, busy=0.
  - State IDLE; register file at defaults.
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles.
- sda_oe rises SYNC_STAGES+2 cycles after the pin-level SCL falling edge following bit 8. It falls the same delay after the SCL falling edge ending the ACK bit.
- reg_wr asserts in the same cycle sda_oe deasserts after ACK1.
- busy rises the cycle START is detected and falls the cycle STOP is detected.
- Simultaneous START/STOP with an SCL edge cannot occur, since SCL is high for both.
- Reset mid-transaction:
  - Abort with no commit, release SDA, restore defaults.
  - The next START is required before any further decode.

## Configuration
- WM_RESET_REG_EN defined: a committed write to address 0x0F with any data reloads all ten registers to defaults in the commit cycle. reg_wr still pulses with reg_addr=0x0F.
- WM_RESET_REG_EN undefined: 0x0F behaves like any other unmapped address (ACK + pulse, no storage change).

## Test plan
- Reset, then write DEV 0x1A, bytes 0x08,0x12 (R4=0x012), STOP:
  - three ACKs; reg_wr one cycle with reg_addr=4, reg_data=0x012.
  - rd_addr=4 gives rd_data=0x012; busy low after STOP.
- Address 0x1B write: SDA never pulled low, no reg_wr, registers unchanged.
- Address 0x1A with R/W=1: no ACK, no reg_wr.
- START, addr, byte 0x0C, then STOP before byte1: no reg_wr, R6 stays 0x09F. A new full write to R6=0x1FF then commits.
- Write R0=0x11F, repeated START, write R1=0x0AA, STOP: two reg_wr pulses, both values stored.
- With WM_RESET_REG_EN: after the R4=0x012 write, write 0x1E,0x00 (reg 0x0F): R4 reads 0x00A. Without the macro: R4 stays 0x012.

Source files
------------

// File: rtl/wm8731_i2c_responder.sv
// rtl/wm8731_i2c_responder.sv - write-only I2C responder emulating the WM8731 control port
// Optional: define WM_RESET_REG_EN to make a write to register 0x0F reload all registers to defaults.
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_BYTE0,
    S_ACK0,
    S_BYTE1,
    S_ACK1,
    S_WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shift_q, shift_n, shifted;
  logic [7:0] byte0_q, byte0_n;
  logic       oe_n;
  logic       commit;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;

  logic [8:0] regs [10];

  function automatic logic [8:0] reg_default(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: reg_default = 9'h097;
      4'd2, 4'd3: reg_default = 9'h079;
      4'd4:       reg_default = 9'h00A;
      4'd5:       reg_default = 9'h008;
      4'd6:       reg_default = 9'h09F;
      4'd7:       reg_default = 9'h00A;
      default:    reg_default = 9'h000;
    endcase
  endfunction

  // Synchronizers reset to the idle-bus level so no spurious edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign wr_addr = byte0_q[7:1];
  assign wr_data = {byte0_q[0], shift_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sda_oe  <= 1'b0;
      bit_cnt <= 3'd0;
      shift_q <= 8'd0;
      byte0_q <= 8'd0;
    end else begin
      state   <= state_n;
      sda_oe  <= oe_n;
      bit_cnt <= cnt_n;
      shift_q <= shift_n;
      byte0_q <= byte0_n;
    end
  end

  always_comb begin
    state_n = state;
    oe_n    = sda_oe;
    cnt_n   = bit_cnt;
    shift_n = shift_q;
    byte0_n = byte0_q;
    commit  = 1'b0;
    shifted = {shift_q[6:0], sda_s};
    if (start_det) begin
      state_n = S_ADDR;
      oe_n    = 1'b0;
      cnt_n   = 3'd0;
    end else if (stop_det) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      cnt_n   = 3'd0;
    end else begin
      case (state)
        S_ADDR, S_BYTE0, S_BYTE1: begin
          if (scl_rise) begin
            shift_n = shifted;
            cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case (state)
                S_ADDR:  state_n = (shifted == {DEV_ADDR, 1'b0}) ? S_ADDR_ACK : S_WAIT_STOP;
                S_BYTE0: begin
                  state_n = S_ACK0;
                  byte0_n = shifted;
                end
                default: state_n = S_ACK1;
              endcase
            end
          end
        end
        // First SCL fall after bit 8 grabs SDA; the next fall releases it and advances.
        S_ADDR_ACK, S_ACK0, S_ACK1: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n = 1'b0;
              case (state)
                S_ADDR_ACK: state_n = S_BYTE0;
                S_ACK0:     state_n = S_BYTE1;
                default: begin
                  state_n = S_WAIT_STOP;
                  commit  = 1'b1;
                end
              endcase
            end
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr   <= 1'b0;
      reg_addr <= 7'd0;
      reg_data <= 9'd0;
      for (int i = 0; i < 10; i++) regs[i] <= reg_default(4'(i));
    end else begin
      reg_wr <= commit;
      if (commit) begin
        reg_addr <= wr_addr;
        reg_data <= wr_data;
        if (wr_addr < 7'd10) begin
          regs[wr_addr[3:0]] <= wr_data;
        end
`ifdef WM_RESET_REG_EN
        else if (wr_addr == 7'h0F) begin
          for (int i = 0; i < 10; i++) regs[i] <= reg_default(4'(i));
        end
`endif
      end
    end
  end

  assign rd_data = (rd_addr < 4'd10) ? regs[rd_addr] : 9'd0;
  assign busy    = ((state != S_IDLE) || start_det) && !stop_det;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb/tb_wm8731_i2c_responder.sv - I2C master bench for wm8731_i2c_responder
module tb_wm8731_i2c_responder;

  localparam int Q = 6;
`ifdef WM_RESET_REG_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, reg_wr, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, rd_data;
  logic [3:0] rd_addr;

  int n_total = 0;
  int n_bad   = 0;

  int   wr_pulses = 0;
  int   wr_high   = 0;
  int   oe_cycles = 0;
  logic wr_q      = 1'b0;

  logic [8:0] model [10];

  assign sda_line = sda_m & ~sda_oe;

  wm8731_i2c_responder dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .reg_wr  (reg_wr),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wr_q <= reg_wr;
    if (reg_wr) wr_high <= wr_high + 1;
    if (reg_wr && !wr_q) wr_pulses <= wr_pulses + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
    end
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = ~sda_line;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic xact(input logic [7:0] dev, input logic [7:0] b0, input logic [7:0] b1,
                      input int nbytes, input bit stop, output int acks);
    logic [7:0] bs [4];
    logic a;
    bs[0] = dev; bs[1] = b0; bs[2] = b1; bs[3] = 8'hA5;
    acks = 0;
    do_start();
    for (int i = 0; i < nbytes; i++) begin
      send_byte(bs[i], a);
      if (a) acks++;
    end
    if (stop) do_stop();
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [8:0] v);
    rd_addr = idx;
    #1;
    v = rd_data;
  endtask

  task automatic model_reset();
    model[0] = 9'h097; model[1] = 9'h097; model[2] = 9'h079; model[3] = 9'h079;
    model[4] = 9'h00A; model[5] = 9'h008; model[6] = 9'h09F; model[7] = 9'h00A;
    model[8] = 9'h000; model[9] = 9'h000;
  endtask

  // A write lands only if the full address + two data bytes were clocked through.
  task automatic model_apply(input logic [7:0] dev, input logic [7:0] b0, input logic [7:0] b1,
                             input int nbytes);
    int a;
    if (dev == 8'h34 && nbytes >= 3) begin
      a = int'(b0[7:1]);
      if (a < 10) model[a] = {b0[0], b1};
      else if (a == 15 && RST_EN) model_reset();
    end
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nbytes;
    int         exp_acks;
    int         exp_wr;
    logic [3:0] rd_idx;
    logic [8:0] rd_exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int acks, w0, o0, exp_acks, exp_wr, r;
    logic [8:0] v;
    logic a;
    logic [7:0] dev, b0, b1;
    int nb;

    vecs[0] = '{8'h34, 8'h08, 8'h12, 3, 3, 1, 4'd4, 9'h012};
    vecs[1] = '{8'h36, 8'h0C, 8'hFF, 3, 0, 0, 4'd6, 9'h09F};
    vecs[2] = '{8'h35, 8'h08, 8'h77, 3, 0, 0, 4'd4, 9'h012};
    vecs[3] = '{8'h34, 8'h0C, 8'h00, 2, 2, 0, 4'd6, 9'h09F};
    vecs[4] = '{8'h34, 8'h0D, 8'hFF, 3, 3, 1, 4'd6, 9'h1FF};
    vecs[5] = '{8'h34, 8'h0E, 8'h55, 4, 3, 1, 4'd7, 9'h055};
    vecs[6] = '{8'h34, 8'h1E, 8'h00, 3, 3, 1, 4'd4, RST_EN ? 9'h00A : 9'h012};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("rst_reg%0d", i), v, (i < 10) ? model[i] : 9'd0);
    end

    for (int t = 0; t < 7; t++) begin
      w0 = wr_pulses; o0 = oe_cycles;
      xact(vecs[t].dev, vecs[t].b0, vecs[t].b1, vecs[t].nbytes, 1'b1, acks);
      model_apply(vecs[t].dev, vecs[t].b0, vecs[t].b1, vecs[t].nbytes);
      check($sformatf("vec%0d_acks", t), acks, vecs[t].exp_acks);
      check($sformatf("vec%0d_wr", t), wr_pulses - w0, vecs[t].exp_wr);
      if (vecs[t].exp_acks == 0) check($sformatf("vec%0d_oe", t), oe_cycles - o0, 0);
      if (vecs[t].exp_wr != 0) begin
        check($sformatf("vec%0d_reg_addr", t), reg_addr, vecs[t].b0[7:1]);
        check($sformatf("vec%0d_reg_data", t), reg_data, {vecs[t].b0[0], vecs[t].b1});
      end
      read_reg(vecs[t].rd_idx, v);
      check($sformatf("vec%0d_rd", t), v, vecs[t].rd_exp);
      check($sformatf("vec%0d_busy", t), busy, 0);
    end

    // Repeated START between two complete writes.
    w0 = wr_pulses;
    xact(8'h34, 8'h01, 8'h1F, 3, 1'b0, acks);
    xact(8'h34, 8'h02, 8'hAA, 3, 1'b1, acks);
    model_apply(8'h34, 8'h01, 8'h1F, 3);
    model_apply(8'h34, 8'h02, 8'hAA, 3);
    check("rs_wr", wr_pulses - w0, 2);
    read_reg(4'd0, v); check("rs_r0", v, 9'h11F);
    read_reg(4'd1, v); check("rs_r1", v, 9'h0AA);

    // Reset mid-transaction: no commit, defaults back, decode waits for a new START.
    w0 = wr_pulses;
    do_start();
    check("mid_busy", busy, 1);
    send_byte(8'h34, a);
    send_byte(8'h08, a);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    read_reg(4'd4, v); check("mid_rst_r4", v, 9'h00A);
    read_reg(4'd0, v); check("mid_rst_r0", v, 9'h097);
    send_byte(8'h12, a);
    check("mid_no_ack", a, 0);
    do_stop();
    check("mid_no_wr", wr_pulses - w0, 0);
    xact(8'h34, 8'h08, 8'h12, 3, 1'b1, acks);
    model_apply(8'h34, 8'h08, 8'h12, 3);
    check("post_rst_acks", acks, 3);
    read_reg(4'd4, v); check("post_rst_r4", v, 9'h012);

    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 3);
      if (r < 2) dev = 8'h34;
      else if (r == 2) dev = ($urandom_range(0, 1) != 0) ? 8'h36 : 8'h35;
      else dev = 8'($urandom);
      b0 = {3'($urandom_range(0, 1) * 0), 4'($urandom_range(0, 15)), 1'($urandom)};
      b1 = 8'($urandom);
      nb = $urandom_range(1, 4);
      exp_acks = (dev == 8'h34) ? ((nb > 3) ? 3 : nb) : 0;
      exp_wr   = (dev == 8'h34 && nb >= 3) ? 1 : 0;
      w0 = wr_pulses;
      xact(dev, b0, b1, nb, 1'b1, acks);
      model_apply(dev, b0, b1, nb);
      check($sformatf("rnd%0d_acks", t), acks, exp_acks);
      check($sformatf("rnd%0d_wr", t), wr_pulses - w0, exp_wr);
      for (int i = 0; i < 16; i++) begin
        read_reg(4'(i), v);
        check($sformatf("rnd%0d_reg%0d", t, i), v, (i < 10) ? model[i] : 9'd0);
      end
    end

    repeat (4) @(negedge clk);
    check("wr_pulse_width", wr_high, wr_pulses);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
